// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command parser.
// The optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      S_HEAD  = 3'd0,
      S_ADDR  = 3'd1,
      S_DHI   = 3'd2,
      S_DLO   = 3'd3,
      S_CSUM  = 3'd4,
      S_WRITE = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   // 8-bit wrap-around checksum accumulation step
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
      return acc + data;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input, register-write output and status pulses of the parser.
// master: the parser; slave: the receiver / register bank / status consumer.
interface uart_cmd_parser_if;

   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic        rx_data_ready;
   logic        reg_wr_req;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr_ack;
   logic        frame_ok;
   logic        frame_err;
   logic [1:0]  err_code;

   modport master (
      input  rx_data, rx_data_valid, reg_wr_ack,
      output rx_data_ready, reg_wr_req, reg_addr, reg_wdata,
             frame_ok, frame_err, err_code
   );

   modport slave (
      output rx_data, rx_data_valid, reg_wr_ack,
      input  rx_data_ready, reg_wr_req, reg_addr, reg_wdata,
             frame_ok, frame_err, err_code
   );

endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter. Counts while run_i is high, restarts on clear_i,
// and flags expired_o while the count sits at TIMEOUT_CYCLES-1.
// Instantiated by uart_cmd_parser only when UART_CMD_TIMEOUT_EN is defined.
module uart_idle_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: restart when cleared or idle, saturate at the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !run_i) begin
         cnt_d = '0;
      end else if (cnt_q != TERMINAL) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = run_i && (cnt_q == TERMINAL);

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: assembles HEADER/ADDR/DHI/DLO/CSUM frames, checks the
// 8-bit checksum and issues one register write per good frame.
// Optional macro UART_CMD_TIMEOUT_EN adds an inter-byte idle timeout.
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter logic [7:0] HEADER = HEADER_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 200000
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_cmd_parser_if.master bus
);

   state_e      state_d,      state_q;
   logic [7:0]  sum_d,        sum_q;
   logic [7:0]  addr_d,       addr_q;
   logic [7:0]  dhi_d,        dhi_q;
   logic [7:0]  dlo_d,        dlo_q;
   logic        reg_wr_req_d, reg_wr_req_q;
   logic [7:0]  reg_addr_d,   reg_addr_q;
   logic [15:0] reg_wdata_d,  reg_wdata_q;
   logic        frame_ok_d,   frame_ok_q;
   logic        frame_err_d,  frame_err_q;
   logic [1:0]  err_code_d,   err_code_q;
   logic        accept_s;
   logic        timeout_s;

   assign bus.rx_data_ready = (state_q != S_WRITE);
   assign accept_s          = bus.rx_data_valid && (state_q != S_WRITE);

`ifdef UART_CMD_TIMEOUT_EN
   logic timer_run_s;
   logic timer_clr_s;

   assign timer_run_s = (state_q == S_ADDR) || (state_q == S_DHI) ||
                        (state_q == S_DLO)  || (state_q == S_CSUM);
   assign timer_clr_s = accept_s || (state_d != state_q);

   uart_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (timer_run_s),
      .clear_i   (timer_clr_s),
      .expired_o (timeout_s)
   );
`else
   assign timeout_s = 1'b0;
`endif

   // Frame FSM, checksum accumulator and write-port next values
   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      addr_d       = addr_q;
      dhi_d        = dhi_q;
      dlo_d        = dlo_q;
      reg_wr_req_d = reg_wr_req_q;
      reg_addr_d   = reg_addr_q;
      reg_wdata_d  = reg_wdata_q;
      frame_ok_d   = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
      case (state_q)
         S_HEAD: begin
            if (accept_s && (bus.rx_data == HEADER)) begin
               sum_d   = 8'h00;
               state_d = S_ADDR;
            end else begin
               state_d = S_HEAD;
            end
         end
         S_ADDR: begin
            if (accept_s) begin
               addr_d  = bus.rx_data;
               sum_d   = csum_add(sum_q, bus.rx_data);
               state_d = S_DHI;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_DHI: begin
            if (accept_s) begin
               dhi_d   = bus.rx_data;
               sum_d   = csum_add(sum_q, bus.rx_data);
               state_d = S_DLO;
            end else begin
               state_d = S_DHI;
            end
         end
         S_DLO: begin
            if (accept_s) begin
               dlo_d   = bus.rx_data;
               sum_d   = csum_add(sum_q, bus.rx_data);
               state_d = S_CSUM;
            end else begin
               state_d = S_DLO;
            end
         end
         S_CSUM: begin
            if (accept_s && (bus.rx_data == sum_q)) begin
               reg_addr_d   = addr_q;
               reg_wdata_d  = {dhi_q, dlo_q};
               reg_wr_req_d = 1'b1;
               state_d      = S_WRITE;
            end else if (accept_s) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_CSUM;
               state_d     = S_HEAD;
            end else begin
               state_d = S_CSUM;
            end
         end
         S_WRITE: begin
            if (bus.reg_wr_ack) begin
               reg_wr_req_d = 1'b0;
               frame_ok_d   = 1'b1;
               state_d      = S_HEAD;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: begin
            reg_wr_req_d = 1'b0;
            state_d      = S_HEAD;
         end
      endcase
      // An idle timeout only fires in the body states; a same-cycle accept wins
      if (timeout_s && !accept_s) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
         state_d     = S_HEAD;
      end else begin
         frame_err_d = frame_err_d;
      end
   end

   // State and output registers; reset aborts any frame or pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_HEAD;
         sum_q        <= 8'h00;
         addr_q       <= 8'h00;
         dhi_q        <= 8'h00;
         dlo_q        <= 8'h00;
         reg_wr_req_q <= 1'b0;
         reg_addr_q   <= 8'h00;
         reg_wdata_q  <= 16'h0000;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         addr_q       <= addr_d;
         dhi_q        <= dhi_d;
         dlo_q        <= dlo_d;
         reg_wr_req_q <= reg_wr_req_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         frame_ok_q   <= frame_ok_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign bus.reg_wr_req = reg_wr_req_q;
   assign bus.reg_addr   = reg_addr_q;
   assign bus.reg_wdata  = reg_wdata_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus a random
// byte stream checked against a frame-level reference model.
module tb_uart_cmd_parser;

   logic clk;
   logic rst_n;
   uart_cmd_parser_if bus();

`ifdef UART_CMD_TIMEOUT_EN
   uart_cmd_parser #(.HEADER(8'hA5), .TIMEOUT_CYCLES(50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
   uart_cmd_parser #(.HEADER(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ack responder settings
   bit ack_en    = 1'b1;
   bit ack_rand  = 1'b0;
   int ack_delay = 1;
   int ack_cnt   = 0;
   int cur_delay = 1;

   // monitor records
   logic [7:0]  mon_addr_q[$];
   logic [15:0] mon_data_q[$];
   int          mon_len_q[$];
   logic [1:0]  mon_err_q[$];
   int mon_ok = 0, mon_both = 0, mon_rdy_wr = 0, mon_unstable = 0, cur_len = 0;
   logic        prev_req = 1'b0;
   logic [7:0]  cur_addr;
   logic [15:0] cur_data;

   // register bank model: acks after a chosen number of request cycles
   always @(negedge clk) begin
      if (!rst_n || !ack_en || !bus.reg_wr_req) begin
         bus.reg_wr_ack = 1'b0;
         ack_cnt = 0;
      end else begin
         if (ack_cnt == 0) cur_delay = ack_rand ? int'($urandom_range(1, 4)) : ack_delay;
         ack_cnt++;
         bus.reg_wr_ack = (ack_cnt == cur_delay);
      end
   end

   // output monitor: writes, request lengths, pulses, stability
   always @(negedge clk) begin
      if (bus.reg_wr_req) begin
         if (!prev_req) begin
            mon_addr_q.push_back(bus.reg_addr);
            mon_data_q.push_back(bus.reg_wdata);
            cur_addr = bus.reg_addr;
            cur_data = bus.reg_wdata;
            cur_len  = 0;
         end else if (bus.reg_addr !== cur_addr || bus.reg_wdata !== cur_data) begin
            mon_unstable++;
         end
         cur_len++;
         if (bus.rx_data_ready) mon_rdy_wr++;
      end else if (prev_req) begin
         mon_len_q.push_back(cur_len);
      end
      prev_req = bus.reg_wr_req;
      if (bus.frame_ok) mon_ok++;
      if (bus.frame_err) mon_err_q.push_back(bus.err_code);
      if (bus.frame_ok && bus.frame_err) mon_both++;
   end

   task automatic clear_mon();
      @(negedge clk); #1;
      mon_addr_q.delete(); mon_data_q.delete(); mon_len_q.delete(); mon_err_q.delete();
      mon_ok = 0; mon_both = 0; mon_rdy_wr = 0; mon_unstable = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      bus.rx_data = b;
      bus.rx_data_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (bus.rx_data_ready) done = 1'b1;
         @(negedge clk);
      end
      bus.rx_data_valid = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL send_byte: byte %02h not accepted within 200 cycles", b);
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] cs);
      send_byte(8'hA5); send_byte(a); send_byte(dh); send_byte(dl); send_byte(cs);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && bus.reg_wr_req; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic check_one_write(input string nm, input logic [7:0] a, input logic [15:0] d);
      checks++;
      if (mon_addr_q.size() != 1) begin
         failures++; $display("FAIL %s_count: got %0d writes, expected 1", nm, mon_addr_q.size());
      end else begin
         checks++;
         if (mon_addr_q[0] !== a || mon_data_q[0] !== d) begin
            failures++; $display("FAIL %s_write: got %02h/%04h, expected %02h/%04h", nm, mon_addr_q[0], mon_data_q[0], a, d);
         end
      end
      checks++;
      if (mon_ok != 1) begin
         failures++; $display("FAIL %s_ok: got %0d frame_ok pulses, expected 1", nm, mon_ok);
      end
   endtask

   task automatic test_reset();
      bus.rx_data_valid = 1'b0;
      bus.rx_data = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.rx_data_ready, bus.reg_wr_req, bus.reg_addr, bus.reg_wdata, bus.frame_ok, bus.frame_err, bus.err_code}
          !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 2'b00}) begin
         failures++;
         $display("FAIL reset_values: rdy=%b req=%b addr=%02h wdata=%04h ok=%b err=%b code=%b, expected 1 0 00 0000 0 0 00",
                  bus.rx_data_ready, bus.reg_wr_req, bus.reg_addr, bus.reg_wdata, bus.frame_ok, bus.frame_err, bus.err_code);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      clear_mon();
      ack_rand = 1'b0; ack_delay = 3;
      send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
      drain();
      check_one_write("good", 8'h12, 16'h3456);
      checks++;
      if (mon_len_q.size() != 1 || mon_len_q[0] != 3) begin
         failures++; $display("FAIL good_req_len: got %0d entries, first %0d, expected 3 cycles", mon_len_q.size(), mon_len_q.size() ? mon_len_q[0] : -1);
      end
      checks++;
      if (mon_rdy_wr != 0 || mon_unstable != 0 || mon_err_q.size() != 0) begin
         failures++; $display("FAIL good_side: ready_in_write=%0d unstable=%0d errs=%0d, expected 0 0 0", mon_rdy_wr, mon_unstable, mon_err_q.size());
      end
   endtask

   task automatic test_bad_csum();
      clear_mon();
      ack_delay = 1;
      send_frame(8'h12, 8'h34, 8'h56, 8'h9D);
      drain();
      checks++;
      if (mon_addr_q.size() != 0 || mon_ok != 0) begin
         failures++; $display("FAIL bad_nowrite: got %0d writes %0d ok, expected 0 0", mon_addr_q.size(), mon_ok);
      end
      checks++;
      if (mon_err_q.size() != 1 || mon_err_q[0] !== 2'b01) begin
         failures++; $display("FAIL bad_err: got %0d errors, first code %b, expected 1 with 01", mon_err_q.size(), mon_err_q.size() ? mon_err_q[0] : 2'bxx);
      end
      checks++;
      if (bus.err_code !== 2'b01) begin
         failures++; $display("FAIL bad_hold: err_code %b, expected held 01", bus.err_code);
      end
      clear_mon();
      send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
      drain();
      check_one_write("bad_then_good", 8'h12, 16'h3456);
   endtask

   task automatic test_garbage();
      clear_mon();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_frame(8'h01, 8'h00, 8'h02, 8'h03);
      drain();
      check_one_write("garbage", 8'h01, 16'h0002);
      checks++;
      if (mon_err_q.size() != 0) begin
         failures++; $display("FAIL garbage_err: got %0d errors, expected 0", mon_err_q.size());
      end
   endtask

   task automatic test_back_to_back();
      bit waited = 1'b0;
      clear_mon();
      ack_delay = 10;
      send_frame(8'h01, 8'h02, 8'h03, 8'h06);
      bus.rx_data = 8'hA5;
      bus.rx_data_valid = 1'b1;
      for (int i = 0; i < 40 && !bus.rx_data_ready; i++) begin
         waited = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (!waited || !bus.rx_data_ready || bus.reg_wr_req !== 1'b0 || bus.frame_ok !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: waited=%b rdy=%b req=%b ok=%b, expected 1 1 0 1", waited, bus.rx_data_ready, bus.reg_wr_req, bus.frame_ok);
      end
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
      send_byte(8'h7F); send_byte(8'h00); send_byte(8'h01); send_byte(8'h80);
      drain();
      checks++;
      if (mon_addr_q.size() != 2 || mon_addr_q[1] !== 8'h7F || mon_data_q[1] !== 16'h0001) begin
         failures++; $display("FAIL bp_second: got %0d writes, expected 2 with second 7F/0001", mon_addr_q.size());
      end
      checks++;
      if (mon_len_q.size() < 1 || mon_len_q[0] != 10 || mon_rdy_wr != 0) begin
         failures++; $display("FAIL bp_hold: req_len=%0d ready_in_write=%0d, expected 10 0", mon_len_q.size() ? mon_len_q[0] : -1, mon_rdy_wr);
      end
      ack_delay = 1;
   endtask

   task automatic test_timeout();
      int first = -1;
      clear_mon();
      send_byte(8'hA5);
      send_byte(8'h12);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (bus.frame_err && first < 0) first = k;
      end
`ifdef UART_CMD_TIMEOUT_EN
      checks++;
      if (first != 50 || mon_err_q.size() != 1 || mon_err_q[0] !== 2'b10) begin
         failures++; $display("FAIL timeout_err: first at %0d errs=%0d, expected cycle 50 one error code 10", first, mon_err_q.size());
      end
`else
      checks++;
      if (first != -1) begin
         failures++; $display("FAIL timeout_none: frame_err at %0d, expected none", first);
      end
      send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      drain();
      check_one_write("no_timeout", 8'h12, 16'h3456);
`endif
   endtask

   task automatic test_reset_mid_write();
      bit saw_req = 1'b0;
      clear_mon();
      ack_en = 1'b0;
      send_frame(8'h44, 8'h55, 8'h66, 8'hFF);
      for (int i = 0; i < 10 && !saw_req; i++) begin
         if (bus.reg_wr_req) saw_req = 1'b1;
         else @(negedge clk);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!saw_req || bus.reg_wr_req !== 1'b0 || bus.rx_data_ready !== 1'b1) begin
         failures++; $display("FAIL rst_write: saw_req=%b req=%b rdy=%b, expected 1 0 1", saw_req, bus.reg_wr_req, bus.rx_data_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ack_en = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (mon_ok != 0 || mon_err_q.size() != 0) begin
         failures++; $display("FAIL rst_pulses: ok=%0d errs=%0d, expected 0 0", mon_ok, mon_err_q.size());
      end
      clear_mon();
      send_frame(8'h21, 8'h00, 8'h10, 8'h31);
      drain();
      check_one_write("after_reset", 8'h21, 16'h0010);
   endtask

   task automatic test_random();
      logic [7:0]  stream[$];
      logic [7:0]  exp_addr[$];
      logic [15:0] exp_data[$];
      int          exp_err;
      logic [7:0]  a, dh, dl, cs, b;
      int          idx;
      clear_mon();
      ack_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h3C;
            stream.push_back(b);
         end
         a  = 8'($urandom);
         dh = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
         dl = 8'($urandom);
         cs = a + dh + dl;
         if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
         stream.push_back(8'hA5); stream.push_back(a); stream.push_back(dh);
         stream.push_back(dl);    stream.push_back(cs);
      end
      // reference: frames start at a header byte and span five bytes
      exp_err = 0;
      idx = 0;
      while (idx < stream.size()) begin
         if (stream[idx] == 8'hA5 && idx + 4 < stream.size()) begin
            cs = stream[idx+1] + stream[idx+2] + stream[idx+3];
            if (cs == stream[idx+4]) begin
               exp_addr.push_back(stream[idx+1]);
               exp_data.push_back({stream[idx+2], stream[idx+3]});
            end else begin
               exp_err++;
            end
            idx += 5;
         end else begin
            idx++;
         end
      end
      foreach (stream[i]) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_byte(stream[i]);
      end
      drain();
      checks++;
      if (mon_addr_q.size() != exp_addr.size() || mon_ok != exp_addr.size()) begin
         failures++; $display("FAIL rand_count: got %0d writes %0d ok, expected %0d", mon_addr_q.size(), mon_ok, exp_addr.size());
      end else begin
         foreach (exp_addr[i]) begin
            checks++;
            if (mon_addr_q[i] !== exp_addr[i] || mon_data_q[i] !== exp_data[i]) begin
               failures++; $display("FAIL rand_write[%0d]: got %02h/%04h, expected %02h/%04h", i, mon_addr_q[i], mon_data_q[i], exp_addr[i], exp_data[i]);
            end
         end
      end
      checks++;
      if (mon_err_q.size() != exp_err) begin
         failures++; $display("FAIL rand_errs: got %0d errors, expected %0d", mon_err_q.size(), exp_err);
      end
      foreach (mon_err_q[i]) begin
         checks++;
         if (mon_err_q[i] !== 2'b01) begin
            failures++; $display("FAIL rand_code[%0d]: got %b, expected 01", i, mon_err_q[i]);
         end
      end
      checks++;
      if (mon_both != 0 || mon_unstable != 0 || mon_rdy_wr != 0) begin
         failures++; $display("FAIL rand_side: both=%0d unstable=%0d ready_in_write=%0d, expected 0 0 0", mon_both, mon_unstable, mon_rdy_wr);
      end
      ack_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_garbage();
      test_back_to_back();
      test_timeout();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
